// File: rtl/mips_cache_pkg.sv
// Shared geometry, line payload and FSM state for the MIPS L1 data cache.
package mips_cache_pkg;

  localparam int unsigned NUM_SETS = 8;
  localparam int unsigned NUM_WAYS = 4;
  localparam int unsigned TAG_W    = 27;
  localparam int unsigned IDX_W    = 3;
  localparam int unsigned WAY_W    = 2;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned BE_W     = 4;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } line_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } cache_state_t;

  // Overlay the enabled byte lanes of wdata onto base.
  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] base,
                                                    input logic [DATA_W-1:0] wdata,
                                                    input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] r;
    r = base;
    for (int i = 0; i < int'(BE_W); i++) begin
      if (be[i]) r[8*i +: 8] = wdata[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/mips_cache_lru.sv
// True-LRU ages for one set; ages stay a permutation of 0..NUM_WAYS-1.
module mips_cache_lru
  import mips_cache_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             access_i,
  input  logic [WAY_W-1:0] way_i,
  output logic [WAY_W-1:0] victim_o
);

  logic [WAY_W-1:0] age_q [NUM_WAYS];
  logic [WAY_W-1:0] age_d [NUM_WAYS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int w = 0; w < int'(NUM_WAYS); w++) age_q[w] <= WAY_W'(w);
    end else begin
      age_q <= age_d;
    end
  end

  // Accessed way becomes youngest; only ways younger than it age by one.
  always_comb begin
    age_d = age_q;
    if (access_i) begin
      for (int w = 0; w < int'(NUM_WAYS); w++) begin
        if (WAY_W'(w) == way_i) begin
          age_d[w] = '0;
        end else if (age_q[w] < age_q[way_i]) begin
          age_d[w] = age_q[w] + WAY_W'(1);
        end
      end
    end
  end

  always_comb begin
    victim_o = '0;
    for (int w = 0; w < int'(NUM_WAYS); w++) begin
      if (age_q[w] == WAY_W'(NUM_WAYS - 1)) victim_o = WAY_W'(w);
    end
  end

endmodule

// File: rtl/mips_data_cache.sv
// 4-way, 8-set, one-word-line L1 data cache with write-allocate and blocking miss fill.
module mips_data_cache
  import mips_cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       addr,
  input  logic              read_en,
  input  logic              write_en,
  input  logic [DATA_W-1:0] writedata,
  input  logic [BE_W-1:0]   byte_en,
  output logic [DATA_W-1:0] readdata,
  output logic              stall,
  output logic [31:0]       data_addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid
);

  line_t             lines_q [NUM_SETS][NUM_WAYS];
  cache_state_t      state_q, state_d;
  logic [DATA_W-1:0] readdata_q;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              hit, free_found, full_write, miss;
  logic [WAY_W-1:0]  hit_way, free_way, victim_way;
  logic [WAY_W-1:0]  lru_victim [NUM_SETS];
  logic [NUM_SETS-1:0] acc_vec;
  line_t             hit_line;

  logic              upd_en, acc_en;
  logic [WAY_W-1:0]  upd_way, acc_way;
  line_t             upd_line;

  assign idx        = addr[IDX_W+1:2];
  assign tag        = addr[31:IDX_W+2];
  assign data_addr  = addr & 32'hFFFF_FFFC;
  assign full_write = &byte_en;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < int'(NUM_WAYS); w++) begin
      if (lines_q[idx][w].valid && (lines_q[idx][w].tag == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Prefer the lowest-numbered empty way, otherwise the set's oldest way.
  always_comb begin
    free_found = 1'b0;
    free_way   = '0;
    for (int w = int'(NUM_WAYS) - 1; w >= 0; w--) begin
      if (!lines_q[idx][w].valid) begin
        free_found = 1'b1;
        free_way   = WAY_W'(w);
      end
    end
  end

  assign victim_way = free_found ? free_way : lru_victim[idx];
  assign hit_line   = lines_q[idx][hit_way];
  assign miss       = (read_en & ~hit) | (write_en & ~hit & ~full_write);
  assign stall      = miss | (state_q == FETCH);
  assign readdata   = (read_en && hit) ? hit_line.data : readdata_q;

  always_comb begin
    state_d  = state_q;
    upd_en   = 1'b0;
    upd_way  = '0;
    upd_line = '0;
    acc_en   = 1'b0;
    acc_way  = '0;
    case (state_q)
      IDLE: begin
        if (miss) begin
          state_d = FETCH;
        end else if (write_en && hit) begin
          upd_en   = 1'b1;
          upd_way  = hit_way;
          upd_line = '{valid: 1'b1, tag: tag,
                       data: merge_bytes(hit_line.data, writedata, byte_en)};
          acc_en   = 1'b1;
          acc_way  = hit_way;
        end else if (write_en) begin
          upd_en   = 1'b1;
          upd_way  = victim_way;
          upd_line = '{valid: 1'b1, tag: tag, data: writedata};
          acc_en   = 1'b1;
          acc_way  = victim_way;
        end else if (read_en) begin
          acc_en  = 1'b1;
          acc_way = hit_way;
        end
      end
      FETCH: begin
        if (data_valid) begin
          state_d  = IDLE;
          upd_en   = 1'b1;
          upd_way  = victim_way;
          upd_line = '{valid: 1'b1, tag: tag,
                       data: merge_bytes(data_in, writedata,
                                         write_en ? byte_en : BE_W'(0))};
          acc_en   = 1'b1;
          acc_way  = victim_way;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      readdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && read_en && hit) readdata_q <= hit_line.data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < int'(NUM_SETS); s++) begin
        for (int w = 0; w < int'(NUM_WAYS); w++) lines_q[s][w] <= '0;
      end
    end else if (upd_en) begin
      lines_q[idx][upd_way] <= upd_line;
    end
  end

  for (genvar s = 0; s < int'(NUM_SETS); s++) begin : g_lru
    assign acc_vec[s] = acc_en && (idx == IDX_W'(s));
    mips_cache_lru u_lru (
      .clk      (clk),
      .rst      (rst),
      .access_i (acc_vec[s]),
      .way_i    (acc_way),
      .victim_o (lru_victim[s])
    );
  end

endmodule

// File: tb/tb_mips_data_cache.sv
// Self-checking bench for mips_data_cache: vector tables, scoreboard queue, word-memory model.
module tb_mips_data_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        read_en, write_en;
  logic [31:0] writedata;
  logic [3:0]  byte_en;
  logic [31:0] readdata;
  logic        stall;
  logic [31:0] data_addr;
  logic [31:0] data_in;
  logic        data_valid;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        exp_stall;
    logic [31:0] exp_rd;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic        exp_stall;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  mips_data_cache dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .read_en    (read_en),
    .write_en   (write_en),
    .writedata  (writedata),
    .byte_en    (byte_en),
    .readdata   (readdata),
    .stall      (stall),
    .data_addr  (data_addr),
    .data_in    (data_in),
    .data_valid (data_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [29:0] n);
    logic [7:0] b;
    b = n[7:0];
    return {b ^ 8'hC3, 8'h5A, b + 8'd17, b ^ 8'h96};
  endfunction

  // Memory answers a stalled request with a one-cycle strobe three cycles later.
  logic [1:0] mcnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcnt       <= '0;
      data_valid <= 1'b0;
      data_in    <= '0;
    end else if (data_valid) begin
      data_valid <= 1'b0;
      mcnt       <= '0;
    end else if (stall) begin
      if (mcnt == 2'd2) begin
        data_valid <= 1'b1;
        data_in    <= mem_word(data_addr[31:2]);
      end
      mcnt <= mcnt + 2'd1;
    end else begin
      mcnt <= '0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; read_en = 1'b0; write_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("reset stall", 32'(stall), 32'd0);
    chk("reset readdata", readdata, 32'd0);
  endtask

  task automatic add_rd(input logic [31:0] a, input logic st, input logic [31:0] rd);
    vecs.push_back('{we: 1'b0, addr: a, wd: 32'd0, be: 4'h0, exp_stall: st, exp_rd: rd});
  endtask

  task automatic add_wr(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                        input logic st);
    vecs.push_back('{we: 1'b1, addr: a, wd: wd, be: be, exp_stall: st, exp_rd: 32'd0});
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    int   n;
    logic [31:0] got;
    e = '{addr: v.addr, exp_stall: v.exp_stall, chk_rd: !v.we, exp_rd: v.exp_rd};
    sb.push_back(e);
    @(negedge clk);
    addr = v.addr; read_en = !v.we; write_en = v.we; writedata = v.wd; byte_en = v.be;
    #1;
    chk($sformatf("data_addr %h", v.addr), data_addr, {v.addr[31:2], 2'b00});
    n = 0;
    while (stall && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    got = readdata;
    e = sb.pop_front();
    if (n >= 40) begin
      total++; bad++;
      $display("FAIL timeout addr %h: stall still high after %0d cycles", e.addr, n);
    end
    chk($sformatf("stall %s %h", v.we ? "wr" : "rd", e.addr), 32'(n > 0), 32'(e.exp_stall));
    if (e.chk_rd) chk($sformatf("readdata %h", e.addr), got, e.exp_rd);
    @(posedge clk);
    #1;
    read_en = 1'b0; write_en = 1'b0;
  endtask

  task automatic run_vecs();
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);
    vecs.delete();
  endtask

  initial begin
    rst = 1'b1; addr = '0; read_en = 1'b0; write_en = 1'b0;
    writedata = '0; byte_en = '0;
    #2;
    do_reset();

    // Temporal locality: each set filled once, then hits.
    for (int i = 0; i < 8; i++) add_rd(32'(i * 4), 1'b1, mem_word(30'(i)));
    for (int i = 0; i < 8; i++) add_rd(32'(i * 4), 1'b0, mem_word(30'(i)));
    run_vecs();

    // Write hits with full byte enable.
    for (int i = 0; i < 8; i++) add_wr(32'(i * 4), 32'(i * i), 4'hF, 1'b0);
    run_vecs();
    @(negedge clk);
    chk("readdata hold", readdata, mem_word(30'd7));
    add_rd(32'h1C, 1'b0, 32'h31);
    add_rd(32'h0C, 1'b0, 32'h09);
    run_vecs();

    // Associativity and LRU replacement in set 0.
    do_reset();
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 4; i++) add_rd(32'(i * 32), p == 0, mem_word(30'(i * 8)));
    add_rd(32'h80, 1'b1, mem_word(30'h20));
    add_rd(32'hA0, 1'b1, mem_word(30'h28));
    add_rd(32'h40, 1'b0, mem_word(30'h10));
    add_rd(32'h80, 1'b0, mem_word(30'h20));
    add_rd(32'hC0, 1'b1, mem_word(30'h30));
    add_rd(32'h40, 1'b0, mem_word(30'h10));
    add_rd(32'hA0, 1'b0, mem_word(30'h28));
    add_rd(32'h80, 1'b0, mem_word(30'h20));
    add_rd(32'h00, 1'b1, mem_word(30'h00));
    run_vecs();

    // Full-word write miss allocates without stalling.
    do_reset();
    for (int i = 0; i < 8; i++) add_wr(32'(i * 4), 32'(i * i), 4'hF, 1'b0);
    for (int i = 0; i < 8; i++) add_rd(32'(i * 4), 1'b0, 32'(i * i));
    run_vecs();

    // Partial write miss merges store lanes into the fetched word.
    do_reset();
    begin
      logic [31:0] m1;
      m1 = mem_word(30'd1);
      add_wr(32'h04, 32'h0000_0001, 4'b0101, 1'b1);
      add_rd(32'h04, 1'b0, {m1[31:24], 8'h00, m1[15:8], 8'h01});
      add_rd(32'h04, 1'b0, {m1[31:24], 8'h00, m1[15:8], 8'h01});
      run_vecs();
    end

    // Reset in the middle of a fill: cache comes up empty and the request re-misses.
    @(negedge clk);
    addr = 32'h44; read_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("fetch stall", 32'(stall), 32'd1);
    rst = 1'b0;
    #1;
    chk("reset in fetch readdata", readdata, 32'd0);
    chk("reset in fetch re-miss", 32'(stall), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    begin
      int n;
      n = 0;
      #1;
      while (stall && n < 40) begin
        @(negedge clk);
        #1;
        n++;
      end
      chk("refill cycles bounded", 32'(n < 40), 32'd1);
      chk("refill readdata", readdata, mem_word(30'h11));
    end
    @(posedge clk);
    #1;
    read_en = 1'b0;
    add_rd(32'h04, 1'b1, mem_word(30'd1));
    run_vecs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
